// File: rtl/psram_nmi_arb_pkg.sv
// Shared definitions for the PSRAM native-memory-port arbiter.
// Holds the state encoding, the native-port field widths and the timeout read-data default.
package psram_nmi_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/nmi_rr_pick.sv
// Combinational round-robin picker: first set request bit after last_i, wrapping modulo NUM_REQ.
// Can be reused by any other arbiter that shares a single port.
module nmi_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [IdxW-1:0]    win_o,
  output logic               any_o
);

  int unsigned    w_sum;
  logic [IdxW-1:0] w_idx;

  // Scan from the farthest offset down to the nearest, so the nearest set bit is the last one written.
  always_comb begin
    win_o = last_i;
    any_o = |req_i;
    w_sum = 0;
    w_idx = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      w_sum = int'(unsigned'(last_i)) + off;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = IdxW'(w_sum);
      if (req_i[w_idx]) win_o = w_idx;
    end
  end

endmodule

// File: rtl/psram_nmi_arb.sv
// Round-robin arbiter that shares the PSRAM controller's native-memory port among NUM_REQ requesters.
// The grant is held for one whole transaction, and a watchdog aborts a stalled transaction.
module psram_nmi_arb
  import psram_nmi_arb_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 3,
  parameter int unsigned       TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic                        mem_valid_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [STRB_W-1:0]           mem_wstrb_o,
  input  logic                        mem_ready_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id_o,
  output logic                        busy_o,
  output logic                        err_o,
  input  logic                        err_clr_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYC == 0) ? '0 : CntW'(TIMEOUT_CYC - 1);

  state_e              r_state;
  logic [IdxW-1:0]     r_gnt;
  logic [NUM_REQ-1:0]  r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic                r_err;
  logic [CntW-1:0]     r_cnt;

  logic [IdxW-1:0]     w_pick;
  logic                w_any;
  logic                w_timeout;
  logic                w_set_err;
  logic [NUM_REQ-1:0]  w_gnt_oh;

  nmi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .req_i  (req_valid_i),
    .last_i (r_gnt),
    .win_o  (w_pick),
    .any_o  (w_any)
  );

  always_comb begin
    w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CntLast);
    // A ready arriving in the same cycle as the timeout completes the transaction normally.
    w_set_err = (r_state == StBusy) && !mem_ready_i && w_timeout;
    w_gnt_oh  = NUM_REQ'(1) << r_gnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_gnt       <= IdxW'(NUM_REQ - 1);
      r_ready     <= '0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_any) begin
            r_gnt       <= w_pick;
            r_mem_addr  <= req_addr_i[w_pick*ADDR_W +: ADDR_W];
            r_mem_wdata <= req_wdata_i[w_pick*DATA_W +: DATA_W];
            r_mem_wstrb <= req_wstrb_i[w_pick*STRB_W +: STRB_W];
            r_mem_valid <= 1'b1;
            r_state     <= StBusy;
          end
        end
        StBusy: begin
          if (mem_ready_i) begin
            r_rdata     <= mem_rdata_i;
            r_mem_valid <= 1'b0;
            r_ready     <= w_gnt_oh;
            r_state     <= StResp;
          end else if (w_timeout) begin
            r_rdata     <= ERR_RDATA;
            r_mem_valid <= 1'b0;
            r_ready     <= w_gnt_oh;
            r_state     <= StResp;
          end else if (r_cnt != {CntW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          r_ready <= '0;
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          r_err <= 1'b0;
    else if (w_set_err) r_err <= 1'b1;
    else if (err_clr_i) r_err <= 1'b0;
  end

  assign req_ready_o = r_ready;
  assign req_rdata_o = r_rdata;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wstrb_o = r_mem_wstrb;
  assign gnt_id_o    = r_gnt;
  assign busy_o      = (r_state != StIdle);
  assign err_o       = r_err;

endmodule

// File: tb/tb_psram_nmi_arb.sv
// Directed bench for psram_nmi_arb with NUM_REQ=3 and TIMEOUT_CYC=8.
// Every expected value below is worked out by hand.
module tb_psram_nmi_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  req_valid_i;
  logic [95:0] req_addr_i;
  logic [95:0] req_wdata_i;
  logic [11:0] req_wstrb_i;
  logic [2:0]  req_ready_o;
  logic [31:0] req_rdata_o;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  gnt_id_o;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;

  int total = 0;
  int bad   = 0;

  psram_nmi_arb #(
    .NUM_REQ     (3),
    .TIMEOUT_CYC (8),
    .ERR_RDATA   (32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .req_ready_o (req_ready_o),
    .req_rdata_o (req_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .gnt_id_o    (gnt_id_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  logic [1:0] exp_order [6];

  initial begin
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0; err_clr_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_gnt", 32'(gnt_id_o), 32'd2);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rdata", req_rdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);

    // mem_ready outside BUSY does nothing
    mem_ready_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    tick();
    chk("idle_ready_ignored", 32'(req_ready_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    mem_ready_i = 1'b0;

    // Single read from requester 0
    req_valid_i = 3'b001; req_addr_i[31:0] = 32'h0000_0010; req_wstrb_i[3:0] = 4'b0000;
    tick();
    chk("rd_mem_valid", 32'(mem_valid_o), 32'd1);
    chk("rd_addr", mem_addr_o, 32'h10);
    chk("rd_gnt", 32'(gnt_id_o), 32'd0);
    chk("rd_busy", 32'(busy_o), 32'd1);
    tick(); tick(); tick();
    chk("rd_wait_ready", 32'(req_ready_o), 32'd0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    chk("rd_ready", 32'(req_ready_o), 32'b001);
    chk("rd_rdata", req_rdata_o, 32'h1234_5678);
    chk("rd_valid_drop", 32'(mem_valid_o), 32'd0);
    mem_ready_i = 1'b0; req_valid_i = '0;
    tick();
    chk("rd_ready_done", 32'(req_ready_o), 32'd0);
    chk("rd_idle", 32'(busy_o), 32'd0);

    // Contention: reset restores gnt_id_o=2 so requester 0 goes first
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_valid_i = 3'b111;
    req_addr_i = {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("cont_gnt%0d", n), 32'(gnt_id_o), 32'(exp_order[n]));
      chk($sformatf("cont_addr%0d", n), mem_addr_o, 32'h0000_0A00 + 32'h100 * 32'(exp_order[n]));
      mem_ready_i = 1'b1; mem_rdata_i = 32'h100 + 32'(n);
      tick();
      chk($sformatf("cont_ready%0d", n), 32'(req_ready_o), 32'(3'b001 << exp_order[n]));
      chk($sformatf("cont_rdata%0d", n), req_rdata_o, 32'h100 + 32'(n));
      mem_ready_i = 1'b0;
      tick();
      chk($sformatf("cont_ready_clr%0d", n), 32'(req_ready_o), 32'd0);
    end
    req_valid_i = '0;

    // Write latch from requester 1 (last grant 2, so the scan starts at 0)
    req_valid_i = 3'b010; req_addr_i[63:32] = 32'h100; req_wdata_i[63:32] = 32'hA5A5_A5A5;
    req_wstrb_i[7:4] = 4'b0011;
    tick();
    chk("wr_gnt", 32'(gnt_id_o), 32'd1);
    chk("wr_addr", mem_addr_o, 32'h100);
    chk("wr_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    req_wdata_i[63:32] = 32'h1111_1111;
    tick();
    chk("wr_wdata_hold", mem_wdata_o, 32'hA5A5_A5A5);
    chk("wr_wstrb", 32'(mem_wstrb_o), 32'b0011);
    chk("wr_valid_hold", 32'(mem_valid_o), 32'd1);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0;
    tick();
    chk("wr_ready", 32'(req_ready_o), 32'b010);
    mem_ready_i = 1'b0; req_valid_i = '0;
    tick();

    // Timeout on requester 2: 8 BUSY cycles, then abort
    req_valid_i = 3'b100; req_addr_i[95:64] = 32'h200; req_wstrb_i[11:8] = 4'b0000;
    tick();
    chk("to_gnt", 32'(gnt_id_o), 32'd2);
    for (int i = 0; i < 7; i++) tick();
    chk("to_valid_before", 32'(mem_valid_o), 32'd1);
    chk("to_err_before", 32'(err_o), 32'd0);
    tick();
    chk("to_valid_drop", 32'(mem_valid_o), 32'd0);
    chk("to_rdata", req_rdata_o, 32'hDEAD_BEEF);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_ready", 32'(req_ready_o), 32'b100);
    req_valid_i = '0;
    tick();
    chk("to_err_sticky", 32'(err_o), 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("to_err_clr", 32'(err_o), 32'd0);

    // mem_ready on the timeout cycle wins over the timeout
    req_valid_i = 3'b001; req_addr_i[31:0] = 32'h300;
    tick();
    chk("col_gnt", 32'(gnt_id_o), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("col_valid_before", 32'(mem_valid_o), 32'd1);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    chk("col_rdata", req_rdata_o, 32'hCAFE_F00D);
    chk("col_err", 32'(err_o), 32'd0);
    chk("col_ready", 32'(req_ready_o), 32'b001);
    mem_ready_i = 1'b0; req_valid_i = '0;
    tick();

    // Reset during BUSY
    req_valid_i = 3'b010;
    tick();
    chk("mr_gnt", 32'(gnt_id_o), 32'd1);
    chk("mr_busy", 32'(busy_o), 32'd1);
    tick();
    rst_i = 1'b1; mem_ready_i = 1'b1;
    tick();
    rst_i = 1'b0; mem_ready_i = 1'b0; req_valid_i = '0;
    chk("mr_valid", 32'(mem_valid_o), 32'd0);
    chk("mr_busy_clr", 32'(busy_o), 32'd0);
    chk("mr_gnt_rst", 32'(gnt_id_o), 32'd2);
    chk("mr_no_ready", 32'(req_ready_o), 32'd0);
    tick();
    chk("mr_no_ready_after", 32'(req_ready_o), 32'd0);
    chk("mr_idle", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_nmi_arb.md
Name: psram_nmi_arb

Overview:
- Shares the single PSRAM controller native-memory port between NUM_REQ requesters, e.g. CPU instruction fetch, CPU data and DMA.
- Arbitration is round-robin. A grant is held for one complete transaction.
- A watchdog times out stalled transactions so the requester is released.
- Sits between the bus crossbar and the PSRAM controller inside the SoC core.

Parameters:
- NUM_REQ, 3: number of requesters, legal range 2..8.
- TIMEOUT_CYC, 1024: cycles in BUSY before abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester transaction valid
- req_addr_i  in  NUM_REQ*32  per-requester address, requester k at bits [k*32+:32]
- req_wdata_i  in  NUM_REQ*32  per-requester write data
- req_wstrb_i  in  NUM_REQ*4  per-requester byte strobes; 0 means read
- req_ready_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_rdata_o  out  32  read data, broadcast to all requesters, valid with req_ready_o
- mem_valid_o  out  1  transaction valid to the PSRAM controller
- mem_addr_o  out  32  latched address
- mem_wdata_o  out  32  latched write data
- mem_wstrb_o  out  4  latched strobes
- mem_ready_i  in  1  PSRAM controller completion
- mem_rdata_i  in  32  PSRAM controller read data
- gnt_id_o  out  $clog2(NUM_REQ)  currently or last granted requester
- busy_o  out  1  high while not in IDLE
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_valid_o=0, req_ready_o=0, req_rdata_o=0, mem_addr_o/wdata_o/wstrb_o=0.
  - gnt_id_o=NUM_REQ-1, so requester 0 wins first.
  - err_o=0, busy_o=0, timeout counter=0.
- State IDLE:
  - If any req_valid_i bit is set, pick the first set bit scanning from gnt_id_o+1, wrapping modulo NUM_REQ.
  - Register the winner into gnt_id_o, latch its addr/wdata/wstrb onto mem_*_o, set mem_valid_o=1, go to BUSY.
  - If no bit is set, stay in IDLE.
- State BUSY:
  - mem_valid_o and mem_* are held constant.
  - On mem_ready_i=1: capture mem_rdata_i into req_rdata_o, drop mem_valid_o, assert req_ready_o[gnt_id_o], go to RESP.
  - Otherwise increment the counter. On the cycle the counter equals TIMEOUT_CYC-1 (with TIMEOUT_CYC≠0): drop mem_valid_o, set req_rdata_o=ERR_RDATA, set err_o, pulse req_ready_o[gnt_id_o], go to RESP.
  - mem_ready_i has priority over timeout in the same cycle.
- State RESP:
  - Lasts one cycle. req_ready_o is high for exactly this cycle; req_rdata_o is valid.
  - Clear the counter, deassert req_ready_o, return to IDLE.
  - No new grant is made in RESP, so the finishing requester has time to drop valid.
- Latency: req_valid_i to mem_valid_o is 1 cycle. mem_ready_i to req_ready_o is 1 cycle. Minimum transaction is 3 cycles.
- Requester protocol: hold valid/addr/wdata/wstrb stable until req_ready_o. Withdrawal during BUSY is ignored; the transaction completes and the ready pulse is still issued.
- Round-robin fairness: every continuously valid requester is granted within NUM_REQ transactions.
- Single requester: back-to-back transactions are granted every 3 cycles.
- mem_ready_i outside BUSY is ignored.
- err_o: sticky. err_clr_i clears it unless a timeout occurs in the same cycle, in which case set wins.
- Reset mid-transaction: on the next edge, state is IDLE, mem_valid_o=0, and no req_ready_o is issued. The PSRAM controller is reset by the same rst_i.
- Width rules: the timeout counter is $clog2(TIMEOUT_CYC+1) bits and saturates, never wraps. Grant index arithmetic is modulo NUM_REQ, including non-power-of-two counts.

Decomposition:
- Package psram_nmi_arb_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - the ERR_RDATA default;
  - the native-memory field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
- Sub-module nmi_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last grant.
  - Outputs: winner index, any-valid.
  - Parameterised by NUM_REQ. Reusable by the other shared-port arbiters.

Test Plan:
- Single read: req0 valid, addr=0x0000_0010, wstrb=0; mem_ready_i 4 cycles after mem_valid_o with rdata=0x1234_5678. Expect mem_addr_o=0x10, req_ready_o=3'b001 for one cycle, req_rdata_o=0x1234_5678.
- Contention: req0/1/2 all continuously valid, mem_ready_i after 1 cycle. Expect grant order 0,1,2,0,1,2 on gnt_id_o and never two req_ready_o bits set together.
- Write latch: req1 writes addr=0x100, wdata=0xA5A5_A5A5, wstrb=4'b0011; change req_wdata_i during BUSY. Expect mem_wdata_o to stay 0xA5A5_A5A5 and mem_wstrb_o=4'b0011.
- Timeout: TIMEOUT_CYC=8, mem_ready_i held 0. Expect mem_valid_o dropped after 8 BUSY cycles, req_rdata_o=0xDEAD_BEEF, err_o=1. Then err_clr_i pulse gives err_o=0.
- Ready/timeout collision: mem_ready_i arrives on the timeout cycle. Expect normal rdata and err_o remaining 0.
- Reset mid-op: rst_i during BUSY. Expect the next cycle IDLE, mem_valid_o=0, no ready pulse, and gnt_id_o=2 with NUM_REQ=3.
